// File: rtl/tone_sequencer.sv
// Multi-channel tone sequencer: edge-detected triggers, fixed-priority preemptive
// arbitration, timed notes rendered as a sawtooth, and a mute toggle.
module tone_sequencer #(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = 8,
  parameter  int DUR_W  = 8,
  parameter  int DAC_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [NUM_CH-1:0]       trig_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [DUR_W-1:0]        dur_i,
  input  logic                    mute_tgl_i,
  output logic [DAC_W-1:0]        dac_o,
  output logic                    active_o,
  output logic [CH_W-1:0]         ch_o,
  output logic                    mode_o
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state;
  logic [NUM_CH-1:0]  trig_q;
  logic               mute_q;
  logic [DIV_W-1:0]   div_l;
  logic [DIV_W-1:0]   cnt;
  logic [DUR_W-1:0]   dur_cnt;

  logic [NUM_CH-1:0]  rise;
  logic               mute_rise;
  logic               win_valid;
  logic [CH_W-1:0]    win_idx;
  logic [DIV_W-1:0]   win_div;
  logic               start;

  // NOTE: combinational logic uses blocking '=' with a default assigned first,
  // so every path drives every signal and no latch is inferred.
  always_comb begin
    rise      = trig_i & ~trig_q;
    mute_rise = mute_tgl_i & ~mute_q;
    win_valid = 1'b0;
    win_idx   = '0;
    // Scan high to low so the lowest-index rise is the last, winning, assignment.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (rise[c]) begin
        win_valid = 1'b1;
        win_idx   = CH_W'(c);
      end
    end
    win_div = div_i[int'(win_idx)*DIV_W +: DIV_W];
    start   = win_valid && ((state == IDLE) || (win_idx <= ch_o));
  end

  assign active_o = (state == PLAY);

  // NOTE: all sequential state uses non-blocking '<=' so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state   <= IDLE;
      trig_q  <= '0;
      mute_q  <= 1'b0;
      mode_o  <= 1'b1;
      ch_o    <= '0;
      div_l   <= '0;
      cnt     <= '0;
      dur_cnt <= '0;
      dac_o   <= '0;
    end else begin
      trig_q <= trig_i;
      mute_q <= mute_tgl_i;
      if (mute_rise || !mode_o) begin
        // A mute rise outranks any same-cycle trigger; OFF holds everything idle.
        if (mute_rise) mode_o <= ~mode_o;
        state   <= IDLE;
        cnt     <= '0;
        dur_cnt <= '0;
        dac_o   <= '0;
      end else if (start) begin
        state   <= PLAY;
        ch_o    <= win_idx;
        div_l   <= win_div;
        cnt     <= '0;
        dur_cnt <= dur_i;
        dac_o   <= '0;
      end else if (state == PLAY) begin
        if (dur_cnt == DUR_W'(1)) begin
          state   <= IDLE;
          cnt     <= '0;
          dur_cnt <= '0;
          dac_o   <= '0;
        end else begin
          // A zero duration never counts down, so the note sustains.
          if (dur_cnt != '0) dur_cnt <= dur_cnt - DUR_W'(1);
          if (cnt == div_l) begin
            cnt   <= '0;
            dac_o <= dac_o + DAC_W'(1);
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: table-driven vectors with a scoreboard
// queue, plus hand-written sequences for asynchronous reset mid-note.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        nRst;
  logic [3:0]  trig_i;
  logic [31:0] div_i;
  logic [7:0]  dur_i;
  logic        mute_tgl_i;
  logic [7:0]  dac_o;
  logic        active_o;
  logic [1:0]  ch_o;
  logic        mode_o;

  tone_sequencer #(.NUM_CH(4), .DIV_W(8), .DUR_W(8), .DAC_W(8)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .trig_i     (trig_i),
    .div_i      (div_i),
    .dur_i      (dur_i),
    .mute_tgl_i (mute_tgl_i),
    .dac_o      (dac_o),
    .active_o   (active_o),
    .ch_o       (ch_o),
    .mode_o     (mode_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  trig;
    logic        mute;
    logic [31:0] div;
    logic [7:0]  dur;
    int          cycles;
    logic        exp_active;
    logic [1:0]  exp_ch;
    logic [7:0]  exp_dac;
    logic        exp_mode;
  } vec_t;

  typedef struct {
    logic       active;
    logic [1:0] ch;
    logic [7:0] dac;
    logic       mode;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  // Divisors packed {ch3, ch2, ch1, ch0}.
  localparam logic [31:0] DIV_A = {8'd5, 8'd2, 8'd3, 8'd1};
  localparam logic [31:0] DIV_Z = {8'd5, 8'd2, 8'd3, 8'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
    else passed++;
  endtask

  task automatic add(input logic [3:0] trig, input logic mute, input logic [31:0] div,
                     input logic [7:0] dur, input int cycles, input logic ea,
                     input logic [1:0] ec, input logic [7:0] ed, input logic em);
    vec_t v;
    v.trig = trig; v.mute = mute; v.div = div; v.dur = dur; v.cycles = cycles;
    v.exp_active = ea; v.exp_ch = ec; v.exp_dac = ed; v.exp_mode = em;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic ea, input logic [1:0] ec, input logic [7:0] ed,
                          input logic em);
    exp_t e;
    e.active = ea; e.ch = ec; e.dac = ed; e.mode = em;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, " active"}, 32'(active_o), 32'(e.active));
    check({tag, " ch"},     32'(ch_o),     32'(e.ch));
    check({tag, " dac"},    32'(dac_o),    32'(e.dac));
    check({tag, " mode"},   32'(mode_o),   32'(e.mode));
  endtask

  initial begin
    nRst = 1'b0; trig_i = '0; div_i = DIV_A; dur_i = 8'd20; mute_tgl_i = 1'b0;

    // Scenario 1: single pulse on ch1, div 3, dur 20.
    add(4'b0000, 0, DIV_A, 20,  2, 0, 0, 0, 1);
    add(4'b0010, 0, DIV_A, 20,  1, 1, 1, 0, 1);  // E0
    add(4'b0000, 0, DIV_A, 20,  3, 1, 1, 0, 1);  // E0+3
    add(4'b0000, 0, DIV_A, 20,  1, 1, 1, 1, 1);  // E0+4 first step
    add(4'b0000, 0, DIV_A, 20, 11, 1, 1, 3, 1);  // E0+15
    add(4'b0000, 0, DIV_A, 20,  4, 1, 1, 4, 1);  // E0+19 last active
    add(4'b0000, 0, DIV_A, 20,  1, 0, 1, 0, 1);  // E0+20 expired
    add(4'b0000, 0, DIV_A, 20,  5, 0, 1, 0, 1);
    // Scenario 2: ch2 dur 50 preempted by ch0; later ch3 discarded.
    add(4'b0100, 0, DIV_A, 50,  1, 1, 2, 0, 1);  // E0
    add(4'b0000, 0, DIV_A, 50,  9, 1, 2, 3, 1);  // E0+9
    add(4'b0001, 0, DIV_A, 50,  1, 1, 0, 0, 1);  // F0 preempt
    add(4'b0000, 0, DIV_A, 50,  4, 1, 0, 2, 1);  // F0+4
    add(4'b1000, 0, DIV_A, 50,  1, 1, 0, 2, 1);  // F0+5 ch3 ignored
    add(4'b0000, 0, DIV_A, 50, 44, 1, 0, 24, 1); // F0+49 still playing
    add(4'b0000, 0, DIV_A, 50,  1, 0, 0, 0, 1);  // F0+50 expired
    add(4'b0000, 0, DIV_A, 50,  3, 0, 0, 0, 1);
    // Scenario 3: ch1 and ch2 rise together; no queued ch2 note.
    add(4'b0110, 0, DIV_A, 20,  1, 1, 1, 0, 1);
    add(4'b0000, 0, DIV_A, 20, 19, 1, 1, 4, 1);
    add(4'b0000, 0, DIV_A, 20,  1, 0, 1, 0, 1);
    add(4'b0000, 0, DIV_A, 20,  5, 0, 1, 0, 1);
    // Scenario 4: div 0 sustain, wrap 255 -> 0, ended by mute.
    add(4'b0001, 0, DIV_Z, 0,   1, 1, 0, 0, 1);
    add(4'b0000, 0, DIV_Z, 0, 255, 1, 0, 255, 1);
    add(4'b0000, 0, DIV_Z, 0,   1, 1, 0, 0, 1);
    add(4'b0000, 0, DIV_Z, 0, 100, 1, 0, 100, 1);
    add(4'b0000, 1, DIV_Z, 0,   1, 0, 0, 0, 0);
    // Scenario 5: OFF ignores triggers; mute rise beats a same-cycle trigger.
    add(4'b0010, 1, DIV_A, 20,  1, 0, 0, 0, 0);
    add(4'b0000, 1, DIV_A, 20,  3, 0, 0, 0, 0);
    add(4'b0000, 0, DIV_A, 20,  1, 0, 0, 0, 0);
    add(4'b0000, 1, DIV_A, 20,  1, 0, 0, 0, 1);  // back ON
    add(4'b0000, 0, DIV_A, 20,  1, 0, 0, 0, 1);
    add(4'b0001, 1, DIV_A, 20,  1, 0, 0, 0, 0);  // mute wins, note dropped
    add(4'b0000, 1, DIV_A, 20,  3, 0, 0, 0, 0);
    add(4'b0000, 0, DIV_A, 20,  1, 0, 0, 0, 0);
    add(4'b0000, 1, DIV_A, 20,  1, 0, 0, 0, 1);
    add(4'b0000, 0, DIV_A, 20,  5, 0, 0, 0, 1);

    // Reset values while held in reset.
    repeat (2) @(negedge clk);
    push_exp(0, 0, 0, 1);
    sb_check("reset");
    nRst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      trig_i = vecs[i].trig; mute_tgl_i = vecs[i].mute;
      div_i  = vecs[i].div;  dur_i      = vecs[i].dur;
      push_exp(vecs[i].exp_active, vecs[i].exp_ch, vecs[i].exp_dac, vecs[i].exp_mode);
      repeat (vecs[i].cycles) @(negedge clk);
      sb_check($sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-note, trigger held through reset.
    trig_i = 4'b0010; div_i = DIV_A; dur_i = 8'd20; mute_tgl_i = 1'b0;
    push_exp(1, 1, 0, 1);
    @(negedge clk);
    sb_check("rst pre start");
    trig_i = 4'b0000;
    push_exp(1, 1, 1, 1);
    repeat (6) @(negedge clk);
    sb_check("rst pre step");
    #2 nRst = 1'b0;
    push_exp(0, 0, 0, 1);
    #1 sb_check("rst async");
    trig_i = 4'b0100;
    @(negedge clk);
    nRst = 1'b1;
    push_exp(1, 2, 0, 1);
    @(negedge clk);
    sb_check("rst release start");
    push_exp(1, 2, 1, 1);
    repeat (3) @(negedge clk);
    sb_check("rst release step");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
